// File: rtl/core2axi_arb_pkg.sv
// Shared types for the two-port core-to-AXI request arbiter.
package core2axi_arb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RESP = 2'd2
  } state_t;

  // Requester index: 0 selects s0, 1 selects s1.
  typedef logic port_t;

  function automatic logic [1:0] port_onehot(input port_t p);
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb_2.sv
// Two-request winner select; the port named by ptr wins a tie.
module rr_arb_2
  import core2axi_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_t      ptr,
  output logic [1:0] gnt_c
);

  always_comb begin
    gnt_c = 2'b00;
    if (ptr == 1'b0) begin
      if (req[0])      gnt_c = 2'b01;
      else if (req[1]) gnt_c = 2'b10;
    end else begin
      if (req[1])      gnt_c = 2'b10;
      else if (req[0]) gnt_c = 2'b01;
    end
  end

endmodule

// File: rtl/core2axi_arb.sv
// Arbitrates two core requesters onto one downstream port, one transaction in flight.
// Define CORE2AXI_ARB_RR_EN for round-robin ties; otherwise port 0 always wins ties.
module core2axi_arb
  import core2axi_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  s0_req_i,
  input  logic [ADDR_WIDTH-1:0] s0_addr_i,
  input  logic                  s0_we_i,
  input  logic [BE_W-1:0]       s0_be_i,
  input  logic [DATA_W-1:0]     s0_wdata_i,
  output logic                  s0_gnt_o,
  output logic                  s0_rvalid_o,
  output logic [DATA_W-1:0]     s0_rdata_o,

  input  logic                  s1_req_i,
  input  logic [ADDR_WIDTH-1:0] s1_addr_i,
  input  logic                  s1_we_i,
  input  logic [BE_W-1:0]       s1_be_i,
  input  logic [DATA_W-1:0]     s1_wdata_i,
  output logic                  s1_gnt_o,
  output logic                  s1_rvalid_o,
  output logic [DATA_W-1:0]     s1_rdata_o,

  output logic                  m_req_o,
  output logic [ADDR_WIDTH-1:0] m_addr_o,
  output logic                  m_we_o,
  output logic [BE_W-1:0]       m_be_o,
  output logic [DATA_W-1:0]     m_wdata_o,
  input  logic                  m_gnt_i,
  input  logic                  m_rvalid_i,
  input  logic [DATA_W-1:0]     m_rdata_i
);

  state_t     state_q, state_d;
  port_t      owner_q, owner_d;
  port_t      prio;
  port_t      win;
  port_t      sel;
  logic [1:0] win_oh;
  logic [1:0] gnt_oh;
  logic [1:0] rvalid_oh;

`ifdef CORE2AXI_ARB_RR_EN
  port_t prio_q, prio_d;

  // Completed owner yields the next tie to the other port.
  always_comb begin
    prio_d = prio_q;
    if (state_q == RESP && m_rvalid_i) prio_d = ~owner_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end

  assign prio = prio_q;
`else
  assign prio = 1'b0;
`endif

  rr_arb_2 u_arb (
    .req   ({s1_req_i, s0_req_i}),
    .ptr   (prio),
    .gnt_c (win_oh)
  );

  assign win = win_oh[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Grant/rvalid follow the downstream handshake in the same cycle.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    sel       = owner_q;
    m_req_o   = 1'b0;
    gnt_oh    = 2'b00;
    rvalid_oh = 2'b00;
    unique case (state_q)
      IDLE: begin
        sel     = win;
        m_req_o = s0_req_i | s1_req_i;
        if (s0_req_i | s1_req_i) begin
          owner_d = win;
          if (m_gnt_i) begin
            gnt_oh  = win_oh;
            state_d = RESP;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        m_req_o = 1'b1;
        if (m_gnt_i) begin
          gnt_oh  = port_onehot(owner_q);
          state_d = RESP;
        end
      end
      RESP: begin
        if (m_rvalid_i) begin
          rvalid_oh = port_onehot(owner_q);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs stay quiet for the whole reset window.
    if (!rst_n) begin
      m_req_o   = 1'b0;
      gnt_oh    = 2'b00;
      rvalid_oh = 2'b00;
    end
  end

  assign m_addr_o  = sel ? s1_addr_i  : s0_addr_i;
  assign m_we_o    = sel ? s1_we_i    : s0_we_i;
  assign m_be_o    = sel ? s1_be_i    : s0_be_i;
  assign m_wdata_o = sel ? s1_wdata_i : s0_wdata_i;

  assign s0_gnt_o    = gnt_oh[0];
  assign s1_gnt_o    = gnt_oh[1];
  assign s0_rvalid_o = rvalid_oh[0];
  assign s1_rvalid_o = rvalid_oh[1];
  assign s0_rdata_o  = m_rdata_i;
  assign s1_rdata_o  = m_rdata_i;

endmodule

// File: tb/tb_core2axi_arb.sv
// Self-checking bench for core2axi_arb: cycle vector table plus a grant-order scoreboard.
module tb_core2axi_arb;

`ifdef CORE2AXI_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s0_req, s1_req, s0_we, s1_we;
  logic [31:0] s0_addr, s1_addr, s0_wdata, s1_wdata;
  logic [3:0]  s0_be, s1_be;
  logic        s0_gnt, s1_gnt, s0_rvalid, s1_rvalid;
  logic [31:0] s0_rdata, s1_rdata;
  logic        m_req, m_we, m_gnt, m_rvalid;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  core2axi_arb #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_req_i(s0_req), .s0_addr_i(s0_addr), .s0_we_i(s0_we), .s0_be_i(s0_be),
    .s0_wdata_i(s0_wdata), .s0_gnt_o(s0_gnt), .s0_rvalid_o(s0_rvalid), .s0_rdata_o(s0_rdata),
    .s1_req_i(s1_req), .s1_addr_i(s1_addr), .s1_we_i(s1_we), .s1_be_i(s1_be),
    .s1_wdata_i(s1_wdata), .s1_gnt_o(s1_gnt), .s1_rvalid_o(s1_rvalid), .s1_rdata_o(s1_rdata),
    .m_req_o(m_req), .m_addr_o(m_addr), .m_we_o(m_we), .m_be_o(m_be), .m_wdata_o(m_wdata),
    .m_gnt_i(m_gnt), .m_rvalid_i(m_rvalid), .m_rdata_i(m_rdata)
  );

  // stim = {s0_req, s1_req, m_gnt, m_rvalid}; exp = {m_req, s0_gnt, s1_gnt, s0_rvalid, s1_rvalid}
  typedef struct {
    logic [3:0]  stim;
    logic [4:0]  exp;
    logic [31:0] addr;
    logic        we;
  } vec_t;

  vec_t vecs[14];
  int   sb_q[$];

  function automatic vec_t mk(input logic [3:0] s, input logic [4:0] e,
                              input logic [31:0] a, input logic w);
    vec_t v;
    v.stim = s; v.exp = e; v.addr = a; v.we = w;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] s);
    {s0_req, s1_req, m_gnt, m_rvalid} = s;
    #3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] outs();
    return {m_req, s0_gnt, s1_gnt, s0_rvalid, s1_rvalid};
  endfunction

  initial begin
    int   exp_w;
    int   model_prio;
    logic [1:0] oh;

    rst_n = 1'b0;
    s0_addr = 32'h1000; s0_we = 1'b0; s0_be = 4'hF; s0_wdata = 32'h0;
    s1_addr = 32'h2004; s1_we = 1'b1; s1_be = 4'hF; s1_wdata = 32'h12345678;
    m_rdata = 32'hDEADBEEF;

    vecs[0]  = mk(4'b1010, 5'b11000, 32'h1000, 1'b0);  // s0 read granted at once
    vecs[1]  = mk(4'b0001, 5'b00010, 32'h0,    1'b0);  // response next cycle
    vecs[2]  = mk(4'b0001, 5'b00000, 32'h0,    1'b0);  // spurious rvalid in IDLE
    vecs[3]  = mk(4'b0000, 5'b00000, 32'h0,    1'b0);
    vecs[4]  = mk(4'b0100, 5'b10000, 32'h2004, 1'b1);  // s1 write, no grant yet
    vecs[5]  = mk(4'b1100, 5'b10000, 32'h2004, 1'b1);  // s0 joins, ignored in HOLD
    vecs[6]  = mk(4'b1100, 5'b10000, 32'h2004, 1'b1);
    vecs[7]  = mk(4'b1100, 5'b10000, 32'h2004, 1'b1);
    vecs[8]  = mk(4'b1100, 5'b10000, 32'h2004, 1'b1);
    vecs[9]  = mk(4'b1110, 5'b10100, 32'h2004, 1'b1);  // grant at cycle 5
    vecs[10] = mk(4'b1010, 5'b00000, 32'h0,    1'b0);  // spurious gnt in RESP
    vecs[11] = mk(4'b1001, 5'b00001, 32'h0,    1'b0);  // s1 response
    vecs[12] = mk(4'b1010, 5'b11000, 32'h1000, 1'b0);  // s0 served afterwards
    vecs[13] = mk(4'b0001, 5'b00010, 32'h0,    1'b0);

    // Reset state with every input active.
    drive(4'b1111);
    check("reset_outs", 32'(outs()), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].stim);
      check($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp));
      check($sformatf("vec%0d_rdata0", i), s0_rdata, m_rdata);
      check($sformatf("vec%0d_rdata1", i), s1_rdata, m_rdata);
      if (vecs[i].exp[4]) begin
        check($sformatf("vec%0d_addr", i), m_addr, vecs[i].addr);
        check($sformatf("vec%0d_we", i), 32'(m_we), 32'(vecs[i].we));
        if (vecs[i].we) begin
          check($sformatf("vec%0d_be", i), 32'(m_be), 32'hF);
          check($sformatf("vec%0d_wdata", i), m_wdata, 32'h12345678);
        end
      end
      tick();
    end

    // Fresh reset so the tie pointer starts at port 0.
    drive(4'b0000);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_prio = 0;

    for (int it = 0; it < 4; it++) begin
      drive(4'b1110);
      sb_q.push_back(RR ? model_prio : 0);
      if (sb_q.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL tie_sb: scoreboard empty at iteration %0d", it);
      end else begin
        exp_w = sb_q.pop_front();
        oh = (exp_w == 1) ? 2'b10 : 2'b01;
        check($sformatf("tie%0d_gnt", it), 32'({s1_gnt, s0_gnt}), 32'(oh));
        tick();
        drive(4'b1101);
        check($sformatf("tie%0d_rvalid", it), 32'({s1_rvalid, s0_rvalid}), 32'(oh));
        check($sformatf("tie%0d_mreq", it), 32'(m_req), 32'h0);
        model_prio = (exp_w == 1) ? 0 : 1;
        tick();
      end
    end

    // s0 completes (pointer moves to s1 under round-robin), then s0 is granted again.
    drive(4'b1010);
    check("pre_s0_gnt", 32'(s0_gnt), 32'h1);
    tick();
    drive(4'b0001);
    check("pre_s0_rvalid", 32'(s0_rvalid), 32'h1);
    tick();
    drive(4'b1010);
    check("rst_s0_gnt", 32'({s1_gnt, s0_gnt}), 32'h1);
    tick();

    // Reset in RESP abandons the transaction.
    rst_n = 1'b0;
    drive(4'b1111);
    check("mid_reset_outs", 32'(outs()), 32'h0);
    tick();
    rst_n = 1'b1;
    drive(4'b0001);
    check("post_reset_rvalid", 32'({s1_rvalid, s0_rvalid}), 32'h0);
    check("post_reset_mreq", 32'(m_req), 32'h0);
    tick();
    drive(4'b1110);
    check("post_reset_tie", 32'({s1_gnt, s0_gnt}), 32'h1);
    tick();
    drive(4'b0001);
    check("post_reset_resp", 32'({s1_rvalid, s0_rvalid}), 32'h1);
    tick();
    drive(4'b0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/core2axi_arb.md
CORE2AXI_ARB -- requirements
Module: core2axi_arb

Interface
REQ-001 SHALL have parameter: ADDR_WIDTH, 32, address width of all ports.
REQ-002 SHALL have port: clk  input  1  clock, all logic on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: s0_req_i/s1_req_i  input  1 each  requester transaction request.
REQ-005 SHALL have ports: s0_gnt_o/s1_gnt_o, s0_rvalid_o/s1_rvalid_o  output  1 each  grant and response valid.
REQ-006 SHALL have ports: s0/s1 _addr_i  input  ADDR_WIDTH; _we_i  input  1; _be_i  input  4; _wdata_i  input  32  request payload.
REQ-007 SHALL have ports: s0_rdata_o/s1_rdata_o  output  32  response data.
REQ-008 SHALL have downstream port set m_req_o, m_addr_o, m_we_o, m_be_o, m_wdata_o (outputs) and m_gnt_i, m_rvalid_i, m_rdata_i (inputs), same widths, driving the core-to-AXI bridge.

Function
REQ-009 SHALL keep at most one transaction outstanding downstream.
REQ-010 SHALL implement FSM states IDLE, HOLD, RESP.
REQ-011 In IDLE: m_req_o = s0_req_i | s1_req_i; payload muxed from combinational winner.
REQ-012 In IDLE with m_gnt_i=1: owner_q <= winner, winner's gnt pulses same cycle, go RESP.
REQ-013 In IDLE with request but m_gnt_i=0: owner_q <= winner, go HOLD; no gnt.
REQ-014 In HOLD: payload and m_req_o from owner_q only; other requester ignored; on m_gnt_i pulse owner gnt same cycle, go RESP.
REQ-015 In RESP: m_req_o=0; on m_rvalid_i, owner rvalid_o=1 same cycle, go IDLE, update priority.
REQ-016 Grant and rvalid latency SHALL be zero added cycles vs downstream; back-to-back transactions need one IDLE cycle minimum after rvalid.
REQ-017 s*_rdata_o SHALL both carry m_rdata_i unconditionally; only rvalid is steered.
REQ-018 Non-owner gnt_o/rvalid_o SHALL be 0 at all times.
REQ-019 Requesters SHALL hold req and payload stable until gnt; owner dropping req in HOLD is illegal, behaviour unspecified.
REQ-020 m_gnt_i/m_rvalid_i in states not expecting them SHALL be ignored.

Reset
REQ-021 Reset SHALL force IDLE, owner_q=0, priority pointer=port 0; all gnt/rvalid outputs and m_req_o 0 while rst_n=0.
REQ-022 Reset mid-transaction SHALL abandon it with no gnt/rvalid emitted afterward for it.

Configuration
REQ-023 With CORE2AXI_ARB_RR_EN defined: round-robin; after a completed transaction of port N, port ~N has priority on next tie.
REQ-024 Without CORE2AXI_ARB_RR_EN: fixed priority, port 0 always wins ties; pointer register absent.

Structure
REQ-025 Package core2axi_arb_pkg SHALL hold the FSM state enum and port-index typedef.
REQ-026 Winner selection SHALL be sub-module rr_arb_2 (2 requests, pointer in, one-hot grant out).

Verification
REQ-027 s0 read addr 0x1000, m_gnt_i same cycle, m_rvalid_i next cycle rdata 0xDEADBEEF -> s0_gnt_o cycle 0, s0_rvalid_o cycle 1 with 0xDEADBEEF, s1 outputs 0.
REQ-028 s0 and s1 request simultaneously, RR_EN on, repeated 4 times -> grant order s0,s1,s0,s1; RR_EN off -> s0 all four while s0 held requesting.
REQ-029 s1 write addr 0x2004 be 0xF wdata 0x12345678, m_gnt_i delayed 5 cycles, s0 requests meanwhile -> m_addr_o stays 0x2004 throughout HOLD, s1_gnt_o at cycle 5, s0 served only after s1_rvalid_o.
REQ-030 Spurious m_rvalid_i in IDLE -> no rvalid_o on either port.
REQ-031 rst_n asserted in RESP after s0 granted, then released, m_rvalid_i pulse -> no s0_rvalid_o, FSM IDLE, next tie won by s0.
